alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Receiving end of the ALU stimulus interface: accepts `{opcode, operand_a, operand_b}` on `load_en`, queues instructions in a small FIFO, executes them in order and presents `alu_out` with the executed `instruction_word`. Single-cycle ops finish one cycle after they are popped. DIV/MOD use an iterative divider. This is the DUT the testbench drives through `tb_ifc`.

## Interface
- `OP_WIDTH`, 16: operand width, signed two's complement.
- `RES_WIDTH`, 2*OP_WIDTH: result width.
- `DEPTH`, 4: instruction FIFO depth, power of two, ≥2.
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `load_en` in 1: push request, sampled at posedge.
- `operand_a`, `operand_b` in OP_WIDTH: signed operands.
- `opcode` in 3: `opcode_t`.
- `ready` out 1: FIFO not full; combinational from occupancy.
- `alu_out` out RES_WIDTH: signed result, registered.
- `instruction_word` out 3+2*OP_WIDTH: `instruction_t` `{opc, op_a, op_b}` of the instruction producing `alu_out`, registered.
- `out_valid` out 1: one-cycle pulse per completed instruction.
- `drop_err` out 1: sticky, set when `load_en` arrives while `ready` is low.

## Operation
- Opcodes: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
- Arithmetic:
  - Operands are sign-extended to RES_WIDTH.
  - ADD/SUB wrap in RES_WIDTH and never overflow.
  - MULT is the full signed product.
  - DIV truncates toward zero.
  - MOD takes the sign of `operand_a`.
  - Divide by zero: DIV gives 0; MOD gives the sign-extended `operand_a`.
- Push: `load_en && ready` writes the FIFO at the posedge. A push with `ready` low is discarded and sets `drop_err`. Only `reset` clears `drop_err`.
- FSM states:
  - IDLE: FIFO non-empty → pop. A non-DIV/MOD op is registered to the outputs at the pop edge, `out_valid`=1, stay in IDLE. DIV/MOD → DIV.
  - DIV: one quotient bit per cycle for OP_WIDTH cycles, no pops, pushes still accepted → DONE.
  - DONE: sign-correct and register the result, `out_valid`=1 → IDLE. No pop occurs in this cycle.
- Simultaneous push and pop on the same edge is legal. Occupancy is unchanged, and `ready` is still judged on the pre-edge count.
- Pointers wrap modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.
- `alu_out` and `instruction_word` hold their value between results.

## Timing
- Reset values: `alu_out`=0, `instruction_word`=0, `out_valid`=0, `drop_err`=0, `ready`=1, FIFO empty, FSM in IDLE.
- Push at edge N into an empty FIFO, idle FSM: pop at edge N+1, and outputs plus `out_valid` are visible after N+1.
- Back-to-back single-cycle ops: one result per cycle.
- DIV/MOD popped at edge P: result plus `out_valid` at edge P+OP_WIDTH+1. The next pop is at P+OP_WIDTH+2.
- Reset asserted mid-divide aborts the operation with no `out_valid`. FIFO contents are lost.

## Configuration
- `ALU_DIV_EN` defined: iterative divider present, DIV/MOD behave as above.
- `ALU_DIV_EN` undefined: no divider and no DIV/DONE states. DIV/MOD complete like single-cycle ops with `alu_out`=0.

## Structure
- `alu_opcodes_pkg` holds:
  - `opcode_t` enum (3-bit)
  - `operand_bit_t` / `operand_logic_t`
  - `instruction_t` packed struct `{opc, op_a, op_b}`
  - the opcode encoding constants
- Sub-module `alu_iter_divider`: unsigned restoring divider, OP_WIDTH iterations, with start/done, quotient and remainder. It is instantiated only under `ALU_DIV_EN`.

## Test plan
- Reset, then ADD a=5 b=-3 → after the next edge `alu_out`=2, `out_valid`=1, `instruction_word`={ADD,5,-3}.
- MULT a=-32768 b=-32768 (OP_WIDTH=16) → `alu_out`=0x4000_0000.
- Five consecutive pushes of PASSA while a DIV is executing (DEPTH=4) → 5th push dropped, `ready`=0 on that edge, `drop_err`=1, four results follow in order.
- DIV a=-7 b=2 → -3 after OP_WIDTH+1 cycles. MOD a=-7 b=2 → -1. DIV a=9 b=0 → 0. MOD a=9 b=0 → 9.
- Reset asserted for 1 ns mid-divide → outputs 0 immediately, no `out_valid`, `ready`=1.
- With `ALU_DIV_EN` undefined, DIV a=8 b=2 → `alu_out`=0 one cycle after the pop.

Source files
------------

// File: rtl/alu_opcodes_pkg.sv
// Shared ALU opcode encoding, operand and instruction word types.
// Latency: none (types, constants and helpers only).
// Backpressure: none.
package alu_opcodes_pkg;

  localparam int ALU_OP_WIDTH = 16;

  localparam logic [2:0] OPC_ZERO  = 3'd0;
  localparam logic [2:0] OPC_PASSA = 3'd1;
  localparam logic [2:0] OPC_PASSB = 3'd2;
  localparam logic [2:0] OPC_ADD   = 3'd3;
  localparam logic [2:0] OPC_SUB   = 3'd4;
  localparam logic [2:0] OPC_MULT  = 3'd5;
  localparam logic [2:0] OPC_DIV   = 3'd6;
  localparam logic [2:0] OPC_MOD   = 3'd7;

  typedef enum logic [2:0] {
    ZERO  = OPC_ZERO,
    PASSA = OPC_PASSA,
    PASSB = OPC_PASSB,
    ADD   = OPC_ADD,
    SUB   = OPC_SUB,
    MULT  = OPC_MULT,
    DIV   = OPC_DIV,
    MOD   = OPC_MOD
  } opcode_t;

  typedef bit   signed [ALU_OP_WIDTH-1:0] operand_bit_t;
  typedef logic signed [ALU_OP_WIDTH-1:0] operand_logic_t;

  typedef struct packed {
    opcode_t        opc;
    operand_logic_t op_a;
    operand_logic_t op_b;
  } instruction_t;

  // DIV and MOD are the only multi-cycle operations.
  function automatic logic is_div_op(input logic [2:0] opc);
    return (opc == OPC_DIV) || (opc == OPC_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; only built when ALU_DIV_EN is defined.
// Latency: start edge loads, WIDTH further edges produce quotient/remainder; done is high during the final iteration cycle.
// Backpressure: none; a new start restarts the divider, reset aborts it.
module alu_iter_divider
  import alu_opcodes_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Partial remainder shifted left with the next dividend bit (dividend bits live in quotient's MSBs).
  assign trial = {remainder, quotient[WIDTH-1]};
  assign fits  = (trial >= {1'b0, dsr});
  assign done  = (cnt == CW'(1));

  // Load operands on start, then shift in one quotient bit per cycle until the count runs out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      cnt       <= CW'(WIDTH);
      dsr       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (cnt != '0) begin
      cnt       <= cnt - 1'b1;
      quotient  <= {quotient[WIDTH-2:0], fits};
      remainder <= fits ? (trial[WIDTH-1:0] - dsr) : trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Instruction FIFO feeding an in-order ALU executor; ALU_DIV_EN adds the iterative DIV/MOD path.
// Latency: single-cycle ops registered at the pop edge; DIV/MOD result OP_WIDTH+1 edges after the pop.
// Backpressure: ready low when the FIFO is full; a push while full is dropped and latches drop_err until reset.
module alu_exec_unit
  import alu_opcodes_pkg::*;
#(
  parameter int OP_WIDTH  = 16,
  parameter int RES_WIDTH = 2*OP_WIDTH,
  parameter int DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [OP_WIDTH-1:0]     operand_a,
  input  logic [OP_WIDTH-1:0]     operand_b,
  input  logic [2:0]              opcode,
  output logic                    ready,
  output logic [RES_WIDTH-1:0]    alu_out,
  output logic [3+2*OP_WIDTH-1:0] instruction_word,
  output logic                    out_valid,
  output logic                    drop_err
);
  localparam int IW = 3 + 2*OP_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int XW = RES_WIDTH - OP_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [IW-1:0]       fifo_mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  logic                idle;
  logic [IW-1:0]       head;
  opcode_t             head_opc;
  logic [OP_WIDTH-1:0] head_a;
  logic [OP_WIDTH-1:0] head_b;

  // ready reflects the pre-edge occupancy, so a pop on the same edge never frees room for a push.
  assign ready    = (count != FULL_CNT);
  assign push     = load_en && ready;
  assign pop      = idle && (count != '0);
  assign head     = fifo_mem[rd_ptr];
  assign head_opc = opcode_t'(head[IW-1 -: 3]);
  assign head_a   = head[2*OP_WIDTH-1 -: OP_WIDTH];
  assign head_b   = head[OP_WIDTH-1:0];

  function automatic logic [RES_WIDTH-1:0] sext(input logic [OP_WIDTH-1:0] v);
    return {{XW{v[OP_WIDTH-1]}}, v};
  endfunction

  // Low RES_WIDTH bits of the sign-extended arithmetic equal the signed result, so no signed types needed.
  function automatic logic [RES_WIDTH-1:0] exec_single(input opcode_t opc,
                                                       input logic [OP_WIDTH-1:0] a,
                                                       input logic [OP_WIDTH-1:0] b);
    logic [RES_WIDTH-1:0] sa;
    logic [RES_WIDTH-1:0] sb;
    logic [RES_WIDTH-1:0] r;
    sa = sext(a);
    sb = sext(b);
    case (opc)
      PASSA:   r = sa;
      PASSB:   r = sb;
      ADD:     r = sa + sb;
      SUB:     r = sa - sb;
      MULT:    r = sa * sb;
      default: r = '0;  // ZERO, and DIV/MOD when no divider is built
    endcase
    return r;
  endfunction

  // Instruction storage, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {opcode, operand_a, operand_b};
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (load_en && !ready) drop_err <= 1'b1;
    end
  end

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t               state;
  logic [IW-1:0]        div_ins;
  logic                 div_start;
  logic                 div_done;
  logic [OP_WIDTH-1:0]  abs_a;
  logic [OP_WIDTH-1:0]  abs_b;
  logic [OP_WIDTH-1:0]  quo;
  logic [OP_WIDTH-1:0]  rem;
  logic [OP_WIDTH-1:0]  d_a;
  logic [OP_WIDTH-1:0]  d_b;
  logic                 d_mod;
  logic [RES_WIDTH-1:0] q_mag;
  logic [RES_WIDTH-1:0] r_mag;
  logic [RES_WIDTH-1:0] div_result;

  assign idle      = (state == S_IDLE);
  assign div_start = pop && is_div_op(head_opc);
  // Magnitudes fit OP_WIDTH unsigned bits even for the most negative operand.
  assign abs_a     = head_a[OP_WIDTH-1] ? (~head_a + 1'b1) : head_a;
  assign abs_b     = head_b[OP_WIDTH-1] ? (~head_b + 1'b1) : head_b;

  alu_iter_divider #(.WIDTH(OP_WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  assign d_a   = div_ins[2*OP_WIDTH-1 -: OP_WIDTH];
  assign d_b   = div_ins[OP_WIDTH-1:0];
  assign d_mod = (opcode_t'(div_ins[IW-1 -: 3]) == MOD);
  assign q_mag = {{XW{1'b0}}, quo};
  assign r_mag = {{XW{1'b0}}, rem};

  // Sign correction: quotient negative when operand signs differ, remainder follows the dividend.
  always_comb begin
    div_result = '0;
    if (d_b == '0) begin
      if (d_mod) div_result = sext(d_a);
    end else if (d_mod) begin
      div_result = d_a[OP_WIDTH-1] ? (~r_mag + 1'b1) : r_mag;
    end else begin
      div_result = (d_a[OP_WIDTH-1] ^ d_b[OP_WIDTH-1]) ? (~q_mag + 1'b1) : q_mag;
    end
  end

  // Executor FSM: single-cycle ops retire at the pop edge, DIV/MOD wait for the divider then retire in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      div_ins          <= '0;
      alu_out          <= '0;
      instruction_word <= '0;
      out_valid        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (div_start) begin
              div_ins <= head;
              state   <= S_DIV;
            end else begin
              alu_out          <= exec_single(head_opc, head_a, head_b);
              instruction_word <= head;
              out_valid        <= 1'b1;
            end
          end
        end
        S_DIV: begin
          if (div_done) state <= S_DONE;
        end
        S_DONE: begin
          alu_out          <= div_result;
          instruction_word <= div_ins;
          out_valid        <= 1'b1;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign idle = 1'b1;

  // Executor: every op, DIV/MOD included, retires at its pop edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out          <= '0;
      instruction_word <= '0;
      out_valid        <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        alu_out          <= exec_single(head_opc, head_a, head_b);
        instruction_word <= head;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: randomized and directed pushes against a transaction-level model.
// Latency: expected results carry the edge number at which out_valid must pulse.
// Backpressure: the model predicts acceptance and drops from its own queue occupancy.
module tb_alu_exec_unit;
  import alu_opcodes_pkg::*;

  localparam int OPW   = 16;
  localparam int RESW  = 2*OPW;
  localparam int IWW   = 3 + 2*OPW;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            load_en;
  logic [OPW-1:0]  operand_a;
  logic [OPW-1:0]  operand_b;
  logic [2:0]      opcode;
  logic            ready;
  logic [RESW-1:0] alu_out;
  logic [IWW-1:0]  instruction_word;
  logic            out_valid;
  logic            drop_err;

  alu_exec_unit #(.OP_WIDTH(OPW), .RES_WIDTH(RESW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .load_en          (load_en),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .opcode           (opcode),
    .ready            (ready),
    .alu_out          (alu_out),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .drop_err         (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     opc;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } ins_t;

  typedef struct {
    logic [RESW-1:0] res;
    logic [IWW-1:0]  iw;
    int              stamp;
  } exp_t;

  ins_t mq[$];     // instructions the model holds in the FIFO
  exp_t expq[$];   // expected results, in order, stamped with their edge
  ins_t pend;
  int   busy;      // edges left until the in-flight divide retires
  bit   drop_m;
  int   edge_no = 0;
  int   checks  = 0;
  int   passes  = 0;

  always @(posedge clk) edge_no++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, got, exp, edge_no);
  endtask

  // Reference arithmetic on plain signed integers.
  function automatic logic [RESW-1:0] ref_result(input ins_t i);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(i.a));
    sb = longint'($signed(i.b));
    case (i.opc)
      OPC_PASSA: r = sa;
      OPC_PASSB: r = sb;
      OPC_ADD:   r = sa + sb;
      OPC_SUB:   r = sa - sb;
      OPC_MULT:  r = sa * sb;
`ifdef ALU_DIV_EN
      OPC_DIV:   r = (sb == 0) ? 0 : sa / sb;
      OPC_MOD:   r = (sb == 0) ? sa : sa % sb;
`endif
      default:   r = 0;
    endcase
    return r[RESW-1:0];
  endfunction

  function automatic bit long_op(input logic [2:0] opc);
`ifdef ALU_DIV_EN
    return (opc == OPC_DIV) || (opc == OPC_MOD);
`else
    return (opc == 3'd0) && (opc != 3'd0);
`endif
  endfunction

  task automatic expect_out(input ins_t i);
    exp_t e;
    e.res   = ref_result(i);
    e.iw    = {i.opc, i.a, i.b};
    e.stamp = edge_no + 1;
    expq.push_back(e);
  endtask

  // Advance the model across the coming edge: pop/retire first, then accept or drop the push.
  task automatic model_edge(input logic le, input ins_t i);
    int   pre;
    ins_t h;
    pre = mq.size();
    if (busy == 0 && pre > 0) begin
      h = mq.pop_front();
      if (long_op(h.opc)) begin
        pend = h;
        busy = OPW + 1;
      end else begin
        expect_out(h);
      end
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) expect_out(pend);
    end
    if (le) begin
      if (pre < DEPTH) mq.push_back(i);
      else drop_m = 1'b1;
    end
  endtask

  task automatic step(input logic le, input logic [2:0] opc, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    ins_t i;
    @(negedge clk);
    #1;
    check("drop_err", drop_err, drop_m);
    check("ready", ready, mq.size() < DEPTH);
    load_en   = le;
    opcode    = opc;
    operand_a = a;
    operand_b = b;
    i.opc = opc;
    i.a   = a;
    i.b   = b;
    model_edge(le, i);
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, OPC_ZERO, '0, '0);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (mq.size() > 0 || busy > 0 || expq.size() > 0); k++)
      step(1'b0, OPC_ZERO, '0, '0);
  endtask

  function automatic logic [OPW-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
  endtask

  // Monitor: every cycle out of reset, out_valid must match whether a result is due at this edge.
  always @(negedge clk) begin
    if (!reset) begin
      bit   due;
      exp_t e;
      due = (expq.size() > 0) && (expq[0].stamp == edge_no);
      check("out_valid", out_valid, due);
      if (due) begin
        e = expq.pop_front();
        if (out_valid) begin
          check("alu_out", alu_out, e.res);
          check("instruction_word", instruction_word, e.iw);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    opcode    = '0;
    operand_a = '0;
    operand_b = '0;
    busy      = 0;
    drop_m    = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_alu_out", alu_out, 0);
    check("rst_instruction_word", instruction_word, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_drop_err", drop_err, 0);
    check("rst_ready", ready, 1);
    reset = 1'b0;

    // ADD 5 + (-3), then MULT of the most negative operands.
    step(1'b1, OPC_ADD, 16'd5, 16'hFFFD);
    run_idle(2);
    step(1'b1, OPC_MULT, 16'h8000, 16'h8000);
    run_idle(2);

    // Back-to-back single-cycle ops.
    step(1'b1, OPC_SUB, 16'd3, 16'd10);
    step(1'b1, OPC_PASSA, 16'h8001, 16'd1);
    step(1'b1, OPC_PASSB, 16'd1, 16'hFFF0);
    step(1'b1, OPC_ZERO, 16'h1234, 16'h5678);
    run_idle(2);

    // Divide corner cases, each run in isolation.
    step(1'b1, OPC_DIV, 16'hFFF9, 16'd2);   run_idle(20);
    step(1'b1, OPC_MOD, 16'hFFF9, 16'd2);   run_idle(20);
    step(1'b1, OPC_DIV, 16'd9, 16'd0);      run_idle(20);
    step(1'b1, OPC_MOD, 16'd9, 16'd0);      run_idle(20);
    step(1'b1, OPC_DIV, 16'd8, 16'd2);      run_idle(20);
    step(1'b1, OPC_DIV, 16'h8000, 16'hFFFF); run_idle(20);
    step(1'b1, OPC_MOD, 16'h8000, 16'd7);   run_idle(20);

    // Five pushes behind a divide: with the divider built the fifth overflows.
    step(1'b1, OPC_DIV, 16'd1000, 16'd3);
    for (int k = 1; k <= 5; k++) step(1'b1, OPC_PASSA, 16'(k), 16'd0);
    drain();

    random_phase(400);
    drain();

    // Async reset pulse with a divide in flight and work queued behind it.
    step(1'b1, OPC_DIV, 16'd1234, 16'd7);
    step(1'b1, OPC_ADD, 16'd1, 16'd1);
    run_idle(4);
    @(negedge clk);
    #1;
    load_en = 1'b0;
    reset   = 1'b1;
    #1;
    check("pulse_alu_out", alu_out, 0);
    check("pulse_instruction_word", instruction_word, 0);
    check("pulse_out_valid", out_valid, 0);
    check("pulse_ready", ready, 1);
    reset = 1'b0;
    mq.delete();
    expq.delete();
    busy   = 0;
    drop_m = 1'b0;
    run_idle(25);

    random_phase(150);
    drain();
    check("scoreboard_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
